// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM sprite DMA arbiter and its bus mux.
package oam_dma_arbiter_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_PORT_ADDR     = 16'h2004;

  // Any non-idle state owns the bus and stalls the CPU.
  function automatic logic is_dma_state(input dma_state_t s);
    return (s != DMA_IDLE);
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus signals of the OAM DMA arbiter.
interface oam_dma_arbiter_if;

  logic [15:0] cpu_addr;
  logic        cpu_r_en;
  logic [7:0]  cpu_w_data;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic        mem_r_en;
  logic [7:0]  mem_w_data;
  logic [7:0]  mem_r_data;
  logic        dma_active;

  // Environment side: the CPU core plus cpu_memory.
  modport master (
    output cpu_addr, cpu_r_en, cpu_w_data, mem_r_data,
    input  cpu_stall, mem_addr, mem_r_en, mem_w_data, dma_active
  );

  // Arbiter side.
  modport slave (
    input  cpu_addr, cpu_r_en, cpu_w_data, mem_r_data,
    output cpu_stall, mem_addr, mem_r_en, mem_w_data, dma_active
  );

endinterface

// File: rtl/oam_dma_bus_mux.sv
// Combinational selection of the memory bus between the CPU and the DMA engine.
module oam_dma_bus_mux
  import oam_dma_arbiter_pkg::*;
(
  input  dma_state_t  state,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r_en,
  input  logic [7:0]  cpu_w_data,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_w_data,
  output logic [15:0] mem_addr,
  output logic        mem_r_en,
  output logic [7:0]  mem_w_data,
  output logic        cpu_stall,
  output logic        dma_active
);

  always_comb begin
    mem_addr   = cpu_addr;
    mem_r_en   = cpu_r_en;
    mem_w_data = cpu_w_data;
    unique case (state)
      // Halt/align cycles keep the CPU address but force a harmless read.
      DMA_HALT, DMA_ALIGN: begin
        mem_r_en = 1'b1;
      end
      DMA_READ: begin
        mem_addr = dma_addr;
        mem_r_en = 1'b1;
      end
      DMA_WRITE: begin
        mem_addr   = dma_addr;
        mem_r_en   = 1'b0;
        mem_w_data = dma_w_data;
      end
      default: begin
      end
    endcase
  end

  assign dma_active = is_dma_state(state);
  assign cpu_stall  = dma_active;

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM sprite DMA: a CPU write to TRIG_ADDR stalls the CPU and copies a page to the OAM port.
// Optional macro OAM_DMA_ALIGN_EN adds the parity-dependent ALIGN cycle.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR     = OAM_DMA_TRIG_ADDR,
  parameter logic [15:0] OAM_PORT_ADDR = oam_dma_arbiter_pkg::OAM_PORT_ADDR,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clock_en,
  oam_dma_arbiter_if.slave bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q,  page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  data_q,  data_d;
  logic [15:0] dma_addr;
`ifdef OAM_DMA_ALIGN_EN
  logic        parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    data_d  = data_q;
`ifdef OAM_DMA_ALIGN_EN
    parity_d = parity_q;
`endif
    if (clock_en) begin
`ifdef OAM_DMA_ALIGN_EN
      parity_d = ~parity_q;
`endif
      unique case (state_q)
        DMA_IDLE: begin
          if (!bus.cpu_r_en && (bus.cpu_addr == TRIG_ADDR)) begin
            page_d  = bus.cpu_w_data;
            index_d = '0;
            state_d = DMA_HALT;
          end
        end
        DMA_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          // The first READ must land on an even cycle; parity_q=1 means the next one is even.
          state_d = parity_q ? DMA_READ : DMA_ALIGN;
`else
          state_d = DMA_READ;
`endif
        end
`ifdef OAM_DMA_ALIGN_EN
        DMA_ALIGN: begin
          state_d = DMA_READ;
        end
`endif
        DMA_READ: begin
          data_d  = bus.mem_r_data;
          state_d = DMA_WRITE;
        end
        DMA_WRITE: begin
          if (index_q == LAST_IDX) begin
            state_d = DMA_IDLE;
          end else begin
            index_d = index_q + 8'd1;
            state_d = DMA_READ;
          end
        end
        default: begin
          state_d = DMA_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DMA_IDLE;
      page_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

`ifdef OAM_DMA_ALIGN_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // The page byte never changes mid-transfer, so there is no carry out of index.
  assign dma_addr = (state_q == DMA_WRITE) ? OAM_PORT_ADDR : {page_q, index_q};

  oam_dma_bus_mux u_mux (
    .state      (state_q),
    .cpu_addr   (bus.cpu_addr),
    .cpu_r_en   (bus.cpu_r_en),
    .cpu_w_data (bus.cpu_w_data),
    .dma_addr   (dma_addr),
    .dma_w_data (data_q),
    .mem_addr   (bus.mem_addr),
    .mem_r_en   (bus.mem_r_en),
    .mem_w_data (bus.mem_w_data),
    .cpu_stall  (bus.cpu_stall),
    .dma_active (bus.dma_active)
  );

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: expected DMA reads/writes queued at trigger time, popped by a bus monitor.
`timescale 1ns/1ps
module tb_oam_dma_arbiter;

  localparam int          XFER = 256;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;

  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic clock_en = 1'b1;

  oam_dma_arbiter_if bus ();
  logic [7:0] mem [0:65535];
  assign bus.mem_r_data = mem[bus.mem_addr];

  oam_dma_arbiter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clock_en (clock_en),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic        tb_par;
  logic [7:0]  exp_wr_q [$];
  logic [15:0] exp_rd_q [$];
  int          stall_cnt, wr_cnt, rd_cnt, exp_stall;
  logic        seen_rd, first_rd_par, exp_rd_par;
  logic [15:0] first_rd, last_rd, ea;
  logic [7:0]  ed;

  // Reference parity: toggles on every enabled cycle after reset.
  always @(posedge clock or negedge reset_n)
    if (!reset_n) tb_par <= 1'b0;
    else if (clock_en) tb_par <= ~tb_par;

  // Bus monitor: one observation per enabled cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_n && clock_en) begin
      if (bus.cpu_stall) stall_cnt++;
      if (bus.dma_active && bus.mem_r_en && bus.mem_addr != bus.cpu_addr) begin
        if (!seen_rd) begin
          seen_rd = 1'b1;
          first_rd = bus.mem_addr;
          first_rd_par = tb_par;
        end
        last_rd = bus.mem_addr;
        rd_cnt++;
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_extra: got addr %h, no read expected", bus.mem_addr);
        end else begin
          ea = exp_rd_q.pop_front();
          if (bus.mem_addr !== ea) begin
            errors++;
            $display("FAIL rd_addr #%0d: got %h want %h", rd_cnt - 1, bus.mem_addr, ea);
          end
        end
      end
      if (bus.dma_active && !bus.mem_r_en) begin
        wr_cnt++;
        checks++;
        if (bus.mem_addr !== OAM) begin
          errors++;
          $display("FAIL wr_addr #%0d: got %h want %h", wr_cnt - 1, bus.mem_addr, OAM);
        end
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_extra: got data %h, no write expected", bus.mem_w_data);
        end else begin
          ed = exp_wr_q.pop_front();
          if (bus.mem_w_data !== ed) begin
            errors++;
            $display("FAIL wr_data #%0d: got %h want %h", wr_cnt - 1, bus.mem_w_data, ed);
          end
        end
      end
    end
  end

  task automatic fill_page(input logic [7:0] page, input logic [7:0] xv);
    for (int i = 0; i < XFER; i++) mem[{page, 8'(i)}] = 8'(i) ^ xv;
  endtask

  // Issues a trigger on a cycle of parity 'odd' and runs until the CPU is released.
  task automatic run_dma(input logic [7:0] page, input logic odd, input bit gate,
                         input int stop_after, output bit done);
    int guard;
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < XFER; i++) begin
      exp_rd_q.push_back({page, 8'(i)});
      exp_wr_q.push_back(mem[{page, 8'(i)}]);
    end
`ifdef OAM_DMA_ALIGN_EN
    exp_stall  = 1 + 2 * XFER + (odd ? 1 : 0);
    exp_rd_par = 1'b0;
`else
    exp_stall  = 1 + 2 * XFER;
    exp_rd_par = odd;
`endif
    stall_cnt = 0; wr_cnt = 0; rd_cnt = 0; seen_rd = 1'b0;
    clock_en = 1'b1;
    guard = 0;
    while (tb_par !== odd && guard < 4) begin
      @(posedge clock); #1;
      guard++;
    end
    bus.cpu_addr = TRIG; bus.cpu_r_en = 1'b0; bus.cpu_w_data = page;
    @(posedge clock); #1;
    bus.cpu_r_en = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 8 * XFER; c++) begin
      if (!bus.cpu_stall) begin done = 1'b1; break; end
      if (stop_after > 0 && wr_cnt >= stop_after) break;
      clock_en = gate ? (c % 3 == 0) : 1'b1;
      @(posedge clock); #1;
    end
    clock_en = 1'b1;
  endtask

  task automatic test_reset();
    bus.cpu_addr = 16'h1234; bus.cpu_r_en = 1'b1; bus.cpu_w_data = 8'h99;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", bus.cpu_stall); end
    checks++; if (bus.dma_active !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", bus.dma_active); end
    checks++; if (bus.mem_addr !== 16'h1234) begin errors++; $display("FAIL rst_addr: got %h want 1234", bus.mem_addr); end
    checks++; if (bus.mem_w_data !== 8'h99) begin errors++; $display("FAIL rst_wdata: got %h want 99", bus.mem_w_data); end
    bus.cpu_addr = TRIG; bus.cpu_r_en = 1'b0; bus.cpu_w_data = 8'h03;
    @(posedge clock); #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_trig_ignored: stall %b want 0", bus.cpu_stall); end
    bus.cpu_addr = 16'h0000; bus.cpu_r_en = 1'b1;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_idle_passthrough();
    bus.cpu_addr = 16'h0123; bus.cpu_r_en = 1'b1; bus.cpu_w_data = 8'h00;
    @(posedge clock); #1;
    checks++; if (bus.mem_addr !== 16'h0123 || bus.mem_r_en !== 1'b1)
      begin errors++; $display("FAIL idle_read: got %h/%b want 0123/1", bus.mem_addr, bus.mem_r_en); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_read_stall: got %b want 0", bus.cpu_stall); end
    bus.cpu_addr = 16'h0200; bus.cpu_r_en = 1'b0; bus.cpu_w_data = 8'h55;
    @(posedge clock); #1;
    checks++; if (bus.mem_addr !== 16'h0200 || bus.mem_r_en !== 1'b0 || bus.mem_w_data !== 8'h55)
      begin errors++; $display("FAIL idle_write: got %h/%b/%h want 0200/0/55", bus.mem_addr, bus.mem_r_en, bus.mem_w_data); end
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_write_stall: got %b want 0", bus.cpu_stall); end
    bus.cpu_addr = 16'h4015; bus.cpu_w_data = 8'h03;
    @(posedge clock); #1;
    bus.cpu_r_en = 1'b1;
    @(posedge clock); #1;
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL near_trig_stall: got %b want 0", bus.cpu_stall); end
  endtask

  task automatic test_basic_dma();
    bit done;
    fill_page(8'h03, 8'h00);
    run_dma(8'h03, 1'b0, 1'b0, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL basic_done: stall still %b after budget", bus.cpu_stall); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL basic_stall: got %0d want %0d", stall_cnt, exp_stall); end
    checks++; if (wr_cnt !== XFER || exp_wr_q.size() != 0) begin errors++; $display("FAIL basic_wr_cnt: got %0d want %0d", wr_cnt, XFER); end
    checks++; if (first_rd !== 16'h0300) begin errors++; $display("FAIL basic_first_rd: got %h want 0300", first_rd); end
    checks++; if (first_rd_par !== exp_rd_par) begin errors++; $display("FAIL basic_rd_par: got %b want %b", first_rd_par, exp_rd_par); end
    checks++; if (bus.mem_addr !== TRIG || bus.dma_active !== 1'b0)
      begin errors++; $display("FAIL basic_idle_after: got %h/%b want 4014/0", bus.mem_addr, bus.dma_active); end
  endtask

  task automatic test_alignment();
    bit done;
    run_dma(8'h03, 1'b1, 1'b0, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL align_done: stall still %b after budget", bus.cpu_stall); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL align_stall: got %0d want %0d", stall_cnt, exp_stall); end
    checks++; if (wr_cnt !== XFER || exp_wr_q.size() != 0) begin errors++; $display("FAIL align_wr_cnt: got %0d want %0d", wr_cnt, XFER); end
    checks++; if (first_rd_par !== exp_rd_par) begin errors++; $display("FAIL align_rd_par: got %b want %b", first_rd_par, exp_rd_par); end
  endtask

  task automatic test_clock_en_gating();
    bit done;
    run_dma(8'h03, 1'b0, 1'b1, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL gate_done: stall still %b after budget", bus.cpu_stall); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL gate_stall: got %0d want %0d", stall_cnt, exp_stall); end
    checks++; if (wr_cnt !== XFER || exp_wr_q.size() != 0) begin errors++; $display("FAIL gate_wr_cnt: got %0d want %0d", wr_cnt, XFER); end
  endtask

  task automatic test_boundary_page();
    bit done;
    fill_page(8'hFF, 8'h5A);
    run_dma(8'hFF, 1'b0, 1'b0, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL ff_done: stall still %b after budget", bus.cpu_stall); end
    checks++; if (rd_cnt !== XFER || last_rd !== 16'hFFFF)
      begin errors++; $display("FAIL ff_last_rd: got %0d reads ending %h want %0d ending ffff", rd_cnt, last_rd, XFER); end
    checks++; if (wr_cnt !== XFER || exp_wr_q.size() != 0) begin errors++; $display("FAIL ff_wr_cnt: got %0d want %0d", wr_cnt, XFER); end
    repeat (2) @(posedge clock);
    #1;
    checks++; if (bus.cpu_stall !== 1'b0 || rd_cnt !== XFER)
      begin errors++; $display("FAIL ff_idle_after: stall %b reads %0d want 0/%0d", bus.cpu_stall, rd_cnt, XFER); end
  endtask

  task automatic test_reset_mid_op();
    bit done;
    fill_page(8'h04, 8'h3C);
    fill_page(8'h02, 8'hA5);
    run_dma(8'h04, 1'b0, 1'b0, 100, done);
    checks++; if (bus.dma_active !== 1'b1 || wr_cnt < 100)
      begin errors++; $display("FAIL mid_active: active %b after %0d writes want 1 after 100", bus.dma_active, wr_cnt); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.cpu_stall !== 1'b0 || bus.dma_active !== 1'b0)
      begin errors++; $display("FAIL mid_rst_async: stall/active %b/%b want 0/0", bus.cpu_stall, bus.dma_active); end
    checks++; if (bus.mem_addr !== TRIG || bus.mem_r_en !== 1'b1)
      begin errors++; $display("FAIL mid_rst_bus: got %h/%b want 4014/1", bus.mem_addr, bus.mem_r_en); end
    exp_wr_q.delete();
    exp_rd_q.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    run_dma(8'h02, 1'b0, 1'b0, 0, done);
    checks++; if (!done) begin errors++; $display("FAIL fresh_done: stall still %b after budget", bus.cpu_stall); end
    checks++; if (first_rd !== 16'h0200 || last_rd !== 16'h02FF)
      begin errors++; $display("FAIL fresh_rd_range: got %h..%h want 0200..02ff", first_rd, last_rd); end
    checks++; if (wr_cnt !== XFER || exp_wr_q.size() != 0) begin errors++; $display("FAIL fresh_wr_cnt: got %0d want %0d", wr_cnt, XFER); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL fresh_stall: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'hEE;
    stall_cnt = 0; wr_cnt = 0; rd_cnt = 0; seen_rd = 1'b0;
    test_reset();
    test_idle_passthrough();
    test_basic_dma();
    test_alignment();
    test_clock_en_gating();
    test_boundary_page();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
